// File: rtl/dual_port_ram.sv
// Simple dual-port flop RAM: port A writes, port B reads with one cycle of latency.
// A write and a read to the same address on the same edge return the new data (write-first).
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [DATA_WIDTH-1:0]            r_data_b;
    logic                             w_bypass;
    logic [DATA_WIDTH-1:0]            w_rd_word;

    assign w_bypass  = we_a && (addr_a == addr_b);
    assign w_rd_word = w_bypass ? data_a : r_mem[addr_b];

    // Flop storage so reset can clear every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (we_a) begin
            r_mem[addr_a] <= data_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_b <= '0;
        end else if (re_b) begin
            r_data_b <= w_rd_word;
        end
    end

    assign data_b = r_data_b;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed stimulus pushes expected read data into a
// scoreboard queue; a monitor pops on every sampled read and checks hold otherwise.
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we_a = 1'b0;
    logic [3:0] addr_a = '0;
    logic [7:0] data_a = '0;
    logic       re_b = 1'b0;
    logic [3:0] addr_b = '0;
    logic [7:0] data_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic [7:0] last_exp = 8'h00;

    dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .re_b(re_b), .addr_b(addr_b), .data_b(data_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, driven on the falling edge; reads push their expectation.
    task automatic drive(input logic we, input logic [3:0] aa, input logic [7:0] da,
                         input logic re, input logic [3:0] ab, input logic [7:0] exp);
        @(negedge clk);
        we_a = we; addr_a = aa; data_a = da;
        re_b = re; addr_b = ab;
        if (re) q.push_back(exp);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 8'h00, 1'b0, addr_b, 8'h00);
    endtask

    always @(negedge rst_n) last_exp = 8'h00;

    // Monitor: each sampled read yields exactly one output to compare.
    always @(posedge clk) begin
        logic s_re, s_rst;
        logic [7:0] e;
        s_re  = re_b;
        s_rst = rst_n;
        #1;
        if (s_rst) begin
            if (s_re) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: got read with data %h, required a queued expectation", data_b);
                end else begin
                    e = q.pop_front();
                    chk("read", data_b, e);
                    last_exp = e;
                end
            end else begin
                chk("hold", data_b, last_exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, required completion before 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 chk("reset_data_b", data_b, 8'h00);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Unwritten location reads 0; then basic write/read and pending write lost on reset
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'h00);
        drive(1'b1, 4'h3, 8'hAA, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'hAA);
        @(negedge clk);
        we_a = 1'b1; addr_a = 4'h3; data_a = 8'h77; re_b = 1'b1; addr_b = 4'h3;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_data_b", data_b, 8'h00);
        @(negedge clk);
        we_a = 1'b0; re_b = 1'b0;
        chk("rst_held_data_b", data_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h00);

        // Basic write/read, then hold with addr_b changed
        drive(1'b1, 4'h3, 8'hAA, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 4'h7, 8'h55, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'hAA);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'h55);
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h3, 8'h00);
        idle(); idle(); idle();

        // Collision: write-first bypass, memory also updated
        drive(1'b1, 4'h5, 8'h11, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 4'h5, 8'h22, 1'b1, 4'h5, 8'h22);
        idle();
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h22);

        // Concurrent write and read to different addresses
        drive(1'b1, 4'hF, 8'hF0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 4'h0, 8'h3C, 1'b1, 4'hF, 8'hF0);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 8'h3C);

        // Full sweep: addr*0x11 everywhere, back-to-back readback
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'(i), 8'(i * 8'h11), 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 16; i++)
            drive(1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 8'(i * 8'h11));
        // we_a=0 with live-looking data must not disturb contents
        for (int i = 0; i < 16; i++)
            drive(1'b0, 4'(i), 8'hC3, 1'b0, 4'h0, 8'h00);
        for (int i = 15; i >= 0; i--)
            drive(1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 8'(i * 8'h11));
        idle(); idle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d queued expectations, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Simple dual-port synchronous RAM: one write-only port (A) and one read-only port (B) sharing a single clock. It is a small register-file-style buffer for passing bytes between a producer and a consumer in the same clock domain. The storage is built from flops, so reset can clear every entry.

Parameters:
DATA_WIDTH, 8, width of each word and of data_a/data_b
ADDR_WIDTH, 4, address width of both ports
DEPTH, 16 (2**ADDR_WIDTH), number of words; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
we_a  input  1  port A write enable
addr_a  input  ADDR_WIDTH  port A write address
data_a  input  DATA_WIDTH  port A write data
re_b  input  1  port B read enable
addr_b  input  ADDR_WIDTH  port B read address
data_b  output  DATA_WIDTH  port B registered read data

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asserted asynchronously):
  - All DEPTH memory words clear to 0 immediately.
  - data_b clears to 0 immediately.
  - State holds at 0 while rst_n stays low.
  - Deassertion is sampled on clk; the first write or read takes effect on the first rising edge with rst_n=1.
- Write, port A: on a rising edge with we_a=1, mem[addr_a] <= data_a. With we_a=0, memory is unchanged. data_a and addr_a are don't-care when we_a=0.
- Read, port B: on a rising edge with re_b=1, data_b <= mem[addr_b].
  - Latency is 1 cycle: data_b is valid immediately after the edge that sampled re_b/addr_b.
  - With re_b=0, data_b holds its last value. It is never forced to 0 or X.
- Simultaneous ops: a write and a read on the same edge to different addresses are independent. Both complete on that edge.
- Collision (we_a=1, re_b=1, addr_a==addr_b on the same edge): write-first. data_b <= data_a (bypass), and the memory also takes data_a.
- Addresses: full range 0..DEPTH-1 is valid. No wrap-around or out-of-range case exists because DEPTH = 2**ADDR_WIDTH.
- Unwritten locations: read 0 after reset.
- Reset mid-operation: a write or read pending on the edge coincident with or after rst_n falling is discarded. Memory and data_b are 0 afterward.
- No handshake, no backpressure. Both ports accept an operation every cycle.
- data_b is driven directly from a flop; there is no combinational path from inputs to data_b.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing 0xAA to addr 3 -> data_b=0x00 immediately. After release, read addr 3 -> data_b=0x00.
- Write/read basic:
  - Stimulus: write 0xAA@3 and 0x55@7 on consecutive edges; drop we_a; read addr 3, then addr 7.
  - Response: data_b=0xAA one cycle after the addr-3 read, then 0x55.
- Hold: after reading 0x55@7, drop re_b and change addr_b to 3 -> data_b stays 0x55 for all following cycles.
- Collision: mem[5]=0x11; on one edge set we_a=1, addr_a=5, data_a=0x22, re_b=1, addr_b=5 -> data_b=0x22 after that edge; a later read of 5 also returns 0x22.
- Concurrent different addresses: write 0x3C@0 while reading addr 15 (previously 0xF0) -> data_b=0xF0; next read of 0 -> 0x3C.
- Full sweep: write value (addr*0x11) to all 16 addresses, then read back 0..15 back-to-back -> each data_b matches one cycle after its address; we_a=0 writes leave contents unchanged.
